exc_vector_ctrl: RTL and testbench

EXC_VECTOR_CTRL -- requirements
Module: exc_vector_ctrl

---
 rtl/exc_vector_ctrl_pkg.sv | 41 ++++
 rtl/exc_prio_enc.sv | 27 ++
 rtl/exc_vector_ctrl.sv | 101 ++++++++++
 tb/tb_exc_vector_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/exc_vector_ctrl_pkg.sv
// Shared definitions for the exception vectoring controller: FSM state
// encoding, IorD address-mux select codes, cause codes and vector addresses.
package exc_vector_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WAIT1   = 3'd2,
        ST_WAIT2   = 3'd3,
        ST_LOAD    = 3'd4
    } state_t;

    // IorD address-mux select codes
    localparam logic [2:0] IORD_PC     = 3'b000;
    localparam logic [2:0] IORD_ALUOUT = 3'b001;
    localparam logic [2:0] IORD_V253   = 3'b010;
    localparam logic [2:0] IORD_V254   = 3'b011;
    localparam logic [2:0] IORD_V255   = 3'b100;

    // Cause codes as seen by software in the cause register
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    // Memory locations holding the handler address byte for each cause
    localparam logic [7:0] VEC_ADDR_OPCODE = 8'd253;
    localparam logic [7:0] VEC_ADDR_OVF    = 8'd254;
    localparam logic [7:0] VEC_ADDR_DIV0   = 8'd255;

    // Map a cause code onto the mux select that addresses its vector byte
    function automatic logic [2:0] cause_to_sel(input logic [1:0] cause);
        case (cause)
            CAUSE_OPCODE: return IORD_V253;
            CAUSE_OVF:    return IORD_V254;
            CAUSE_DIV0:   return IORD_V255;
            default:      return IORD_PC;
        endcase
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder for exception requests: opcode > overflow > div0.
module exc_prio_enc
    import exc_vector_ctrl_pkg::*;
(
    input  logic       req_opcode,
    input  logic       req_ovf,
    input  logic       req_div0,
    output logic [1:0] cause,
    output logic       valid
);

    // Pick the highest-priority pending request
    always_comb begin
        cause = CAUSE_NONE;
        valid = 1'b1;
        if (req_opcode) begin
            cause = CAUSE_OPCODE;
        end else if (req_ovf) begin
            cause = CAUSE_OVF;
        end else if (req_div0) begin
            cause = CAUSE_DIV0;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/exc_vector_ctrl.sv
// Exception vectoring controller: on an accepted exception it writes
// PC-4 into EPC, steers the address mux at the cause's vector byte, waits
// out the memory latency and loads the zero-extended byte into the PC.
module exc_vector_ctrl
    import exc_vector_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exc_opcode,
    input  logic              exc_ovf,
    input  logic              exc_div0,
    input  logic [2:0]        iord_req,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] mem_data,
    output logic [2:0]        iord_sel,
    output logic [DATA_W-1:0] epc_out,
    output logic              epc_write,
    output logic [DATA_W-1:0] pc_out,
    output logic              pc_write,
    output logic [1:0]        cause_out,
    output logic              exc_active
);

    state_t     state;
    logic [2:0] vec_sel;
    logic [1:0] enc_cause;
    logic       enc_valid;
    logic       unused_mem_hi;

    // The PC has already advanced past the faulting instruction; wraps at zero
    function automatic logic [DATA_W-1:0] epc_addr(input logic [DATA_W-1:0] pc);
        return pc - DATA_W'(4);
    endfunction

    exc_prio_enc u_prio_enc (
        .req_opcode (exc_opcode),
        .req_ovf    (exc_ovf),
        .req_div0   (exc_div0),
        .cause      (enc_cause),
        .valid      (enc_valid)
    );

    // Sequence FSM with registered enables; requests are only seen in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cause_out  <= CAUSE_NONE;
            vec_sel    <= IORD_PC;
            epc_write  <= 1'b0;
            pc_write   <= 1'b0;
            exc_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state      <= ST_CAPTURE;
                        cause_out  <= enc_cause;
                        vec_sel    <= cause_to_sel(enc_cause);
                        epc_write  <= 1'b1;
                        exc_active <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state     <= ST_WAIT1;
                    epc_write <= 1'b0;
                end
                ST_WAIT1: begin
                    state <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    state    <= ST_LOAD;
                    pc_write <= 1'b1;
                end
                ST_LOAD: begin
                    state      <= ST_IDLE;
                    pc_write   <= 1'b0;
                    exc_active <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    epc_write  <= 1'b0;
                    pc_write   <= 1'b0;
                    exc_active <= 1'b0;
                end
            endcase
        end
    end

    // Address mux follows the control unit unless a sequence owns it
    assign iord_sel = exc_active ? vec_sel : iord_req;

    // Write data is forced to zero outside its enable pulse
    assign epc_out = epc_write ? epc_addr(pc_in) : '0;
    assign pc_out  = pc_write ? {{(DATA_W-8){1'b0}}, mem_data[7:0]} : '0;

    // Only the low byte of the vector location is a handler address
    assign unused_mem_hi = ^mem_data[DATA_W-1:8];

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Directed bench for exc_vector_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_exc_vector_ctrl;

    logic        clk;
    logic        reset;
    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic [2:0]  iord_req;
    logic [31:0] pc_in;
    logic [31:0] mem_data;
    logic [2:0]  iord_sel;
    logic [31:0] epc_out;
    logic        epc_write;
    logic [31:0] pc_out;
    logic        pc_write;
    logic [1:0]  cause_out;
    logic        exc_active;

    int tests_run;
    int tests_failed;

    exc_vector_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_div0   (exc_div0),
        .iord_req   (iord_req),
        .pc_in      (pc_in),
        .mem_data   (mem_data),
        .iord_sel   (iord_sel),
        .epc_out    (epc_out),
        .epc_write  (epc_write),
        .pc_out     (pc_out),
        .pc_write   (pc_write),
        .cause_out  (cause_out),
        .exc_active (exc_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset      = 1'b0;
        exc_opcode = 1'b0;
        exc_ovf    = 1'b0;
        exc_div0   = 1'b0;
        iord_req   = 3'b001;
        pc_in      = 32'h0;
        mem_data   = 32'h0;

        // Reset state
        #3;
        chk("rst_active", exc_active, 0);
        chk("rst_epcw", epc_write, 0);
        chk("rst_pcw", pc_write, 0);
        chk("rst_cause", cause_out, 0);
        chk("rst_sel", iord_sel, 3'b001);
        tick();
        reset = 1'b1;

        // Idle: select tracks request combinationally
        tick();
        iord_req = 3'b000; #1;
        chk("idle_sel0", iord_sel, 3'b000);
        iord_req = 3'b001; #1;
        chk("idle_sel1", iord_sel, 3'b001);
        chk("idle_epcw", epc_write, 0);
        chk("idle_pcw", pc_write, 0);
        chk("idle_epc0", epc_out, 0);

        // Overflow sequence, div0 pulse during WAIT1 ignored
        exc_ovf = 1'b1; pc_in = 32'h0000_0108; mem_data = 32'hDEAD_BE40; #1;
        chk("ovf_pre_active", exc_active, 0);
        tick();                                   // CAPTURE
        exc_ovf = 1'b0; iord_req = 3'b001; #1;
        chk("ovf_cap_epc", epc_out, 32'h104);
        chk("ovf_cap_epcw", epc_write, 1);
        chk("ovf_cap_sel", iord_sel, 3'b011);
        chk("ovf_cap_active", exc_active, 1);
        chk("ovf_cap_cause", cause_out, 2'b10);
        chk("ovf_cap_pcw", pc_write, 0);
        tick();                                   // WAIT1
        exc_div0 = 1'b1; #1;
        chk("ovf_w1_epcw", epc_write, 0);
        chk("ovf_w1_epc", epc_out, 0);
        chk("ovf_w1_sel", iord_sel, 3'b011);
        tick();                                   // WAIT2
        exc_div0 = 1'b0; #1;
        chk("ovf_w2_cause", cause_out, 2'b10);
        chk("ovf_w2_pcw", pc_write, 0);
        tick();                                   // LOAD
        #1;
        chk("ovf_ld_pc", pc_out, 32'h40);
        chk("ovf_ld_pcw", pc_write, 1);
        chk("ovf_ld_sel", iord_sel, 3'b011);
        chk("ovf_ld_active", exc_active, 1);
        tick();                                   // IDLE
        #1;
        chk("ovf_end_active", exc_active, 0);
        chk("ovf_end_pcw", pc_write, 0);
        chk("ovf_end_pc", pc_out, 0);
        chk("ovf_end_sel", iord_sel, 3'b001);
        tick();
        chk("ovf_noqueue_active", exc_active, 0);
        chk("ovf_hold_cause", cause_out, 2'b10);

        // Opcode and div0 together: opcode wins for all four cycles
        exc_opcode = 1'b1; exc_div0 = 1'b1; iord_req = 3'b000;
        tick();
        exc_opcode = 1'b0; exc_div0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("prio_sel_%0d", i), iord_sel, 3'b010);
            chk($sformatf("prio_cause_%0d", i), cause_out, 2'b01);
            chk($sformatf("prio_active_%0d", i), exc_active, 1);
            if (i == 3) exc_ovf = 1'b1;           // sampled on LOAD->IDLE edge
            if (i < 3) tick();
        end
        tick();                                   // back in IDLE
        exc_ovf = 1'b0; #1;
        chk("load_edge_ignored", exc_active, 0);
        chk("load_edge_cause", cause_out, 2'b01);
        tick();
        chk("load_edge_still_idle", exc_active, 0);

        // Div0 at PC 0: EPC wraps
        exc_div0 = 1'b1; pc_in = 32'h0; mem_data = 32'h1234_56AB;
        tick();
        exc_div0 = 1'b0; #1;
        chk("div0_epc", epc_out, 32'hFFFF_FFFC);
        chk("div0_sel", iord_sel, 3'b100);
        chk("div0_cause", cause_out, 2'b11);
        tick(); tick(); tick();                   // LOAD
        chk("div0_pc", pc_out, 32'h0000_00AB);
        chk("div0_pcw", pc_write, 1);
        tick();
        chk("div0_end_active", exc_active, 0);

        // Reset during WAIT2
        exc_ovf = 1'b1; pc_in = 32'h200; iord_req = 3'b001;
        tick();                                   // CAPTURE
        exc_ovf = 1'b0;
        tick();                                   // WAIT1
        tick();                                   // WAIT2
        reset = 1'b0; #1;
        chk("rstmid_active", exc_active, 0);
        chk("rstmid_cause", cause_out, 0);
        chk("rstmid_sel", iord_sel, 3'b001);
        chk("rstmid_epcw", epc_write, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstmid_nopcw_%0d", i), pc_write, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstrel_nopcw_%0d", i), pc_write, 0);
        end
        iord_req = 3'b000; #1;
        chk("rstrel_sel0", iord_sel, 3'b000);
        iord_req = 3'b001; #1;
        chk("rstrel_sel1", iord_sel, 3'b001);
        chk("rstrel_active", exc_active, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
